pipe_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage CPU datapath (IF, RF, ALU, DM, WB). It tracks destination registers in flight in a 3-entry shadow pipeline that mirrors the ALU, DM and WB stages. From that it decides when the RF-stage instruction must stall, gates branch/jump redirects, and squashes the wrong-path instruction after a taken redirect. It also keeps stall and flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and sequencing controller for a 5-stage datapath (IF, RF, ALU, DM,
// WB). A 3-entry shadow pipeline (E/M/W) mirrors the destination registers
// of the instructions sitting in the ALU, DM and WB stages. The RF-stage
// instruction is checked against it to decide whether it must stall.
// Branch/jump redirects are gated, and the wrong-path instruction that
// follows a taken redirect is squashed for one cycle.
//
// Optional feature (compile-time macro): HAZARD_FWD_EN
//   undefined : any RAW match in E/M/W stalls; fwd_a/fwd_b are tied to 0.
//   defined   : the youngest matching entry is forwarded. A stall happens
//               only when that entry is a late producer (result final at WB)
//               and still sits in E or M.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high
//   rf_opc   [5:0] in   opcode of the RF-stage instruction
//   rf_rs1   [4:0] in   RS1 field
//   rf_rs2   [4:0] in   RS2 field
//   rf_rd    [4:0] in   RD field
//   redirect_req   in   branch/jump condition true for the RF instruction
//   stall          out  comb: hold PC and IF/RF latch, bubble into ALU
//   take_redirect  out  comb: PC select (redirect_req & ~stall & ~flush)
//   flush          out  reg : RF instruction is wrong-path, bubble into ALU
//   fwd_a    [1:0] out  operand A source: 0 RF, 1 ALU, 2 DM, 3 WB
//   fwd_b    [1:0] out  operand B source, same encoding
//   stall_cnt      out  saturating count of stall cycles
//   flush_cnt      out  saturating count of flush cycles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       rf_opc,
  input  logic [4:0]       rf_rs1,
  input  logic [4:0]       rf_rs2,
  input  logic [4:0]       rf_rd,
  input  logic             redirect_req,
  output logic             stall,
  output logic             take_redirect,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // One in-flight producer: its destination register and whether its result
  // only becomes available at WB.
  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       late;
  } entry_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  entry_t           e_q, e_d;
  entry_t           m_q, m_d;
  entry_t           w_q, w_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // -------------------------------------------------------------------------
  // Opcode decode of the RF-stage instruction
  // -------------------------------------------------------------------------
  logic       uses_rs1;
  logic       uses_rs2;
  logic       writes;
  logic       late_op;
  logic [4:0] dest;

  always_comb begin
    uses_rs1 = rf_opc inside {[6'd1:6'd15], [6'd17:6'd21]};
    uses_rs2 = rf_opc inside {6'd1, 6'd2, [6'd6:6'd14]};
    writes   = rf_opc inside {6'd1, 6'd2, [6'd4:6'd20]};
    late_op  = rf_opc inside {6'd4, [6'd6:6'd11]};
    // Immediate-form and load-style opcodes name their target in RS2.
    dest     = (rf_opc inside {6'd4, 6'd5, [6'd15:6'd20]}) ? rf_rs2 : rf_rd;
  end

  function automatic logic hit(input entry_t ent, input logic [4:0] r);
    return ent.valid && (ent.dest == r);
  endfunction

  // -------------------------------------------------------------------------
  // RAW hazard detection and forwarding selects
  // -------------------------------------------------------------------------
  logic raw_a;
  logic raw_b;

`ifdef HAZARD_FWD_EN
  // Youngest matching producer wins: E (1) over M (2) over W (3); 0 = none.
  function automatic logic [1:0] src_sel(input entry_t e, input entry_t m,
                                         input entry_t w, input logic [4:0] r);
    logic [1:0] sel;
    sel = 2'd0;
    if (hit(e, r))      sel = 2'd1;
    else if (hit(m, r)) sel = 2'd2;
    else if (hit(w, r)) sel = 2'd3;
    return sel;
  endfunction

  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       unused_w_late;

  // Only a late producer still in E or M cannot be forwarded; in W its
  // final value is on the WB bus.
  always_comb begin
    sel_a = src_sel(e_q, m_q, w_q, rf_rs1);
    sel_b = src_sel(e_q, m_q, w_q, rf_rs2);
    raw_a = uses_rs1 &&
            (((sel_a == 2'd1) && e_q.late) || ((sel_a == 2'd2) && m_q.late));
    raw_b = uses_rs2 &&
            (((sel_b == 2'd1) && e_q.late) || ((sel_b == 2'd2) && m_q.late));
    fwd_a = (reset || !uses_rs1) ? 2'd0 : sel_a;
    fwd_b = (reset || !uses_rs2) ? 2'd0 : sel_b;
  end

  // The late flag of W is never needed: W is always forwardable.
  assign unused_w_late = w_q.late;
`else
  logic unused_late;

  // Without forwarding, any in-flight writer of a source register blocks
  // issue until it has left W and the register file holds the value.
  always_comb begin
    raw_a = uses_rs1 && (hit(e_q, rf_rs1) || hit(m_q, rf_rs1) || hit(w_q, rf_rs1));
    raw_b = uses_rs2 && (hit(e_q, rf_rs2) || hit(m_q, rf_rs2) || hit(w_q, rf_rs2));
  end

  assign fwd_a       = 2'd0;
  assign fwd_b       = 2'd0;
  assign unused_late = e_q.late ^ m_q.late ^ w_q.late;
`endif

  // -------------------------------------------------------------------------
  // Stall / redirect / flush
  // -------------------------------------------------------------------------
  // A flushed instruction is squashed anyway, so it never stalls; this also
  // keeps a stall from extending the wrong-path slot.
  assign stall         = !reset && !flush_q && (raw_a || raw_b);
  assign take_redirect = !reset && redirect_req && !stall && !flush_q;
  assign flush         = flush_q;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here is given a value on every path (the
  // defaults at the top), so no latch can be inferred.
  always_comb begin
    e_d         = '0;
    m_d         = e_q;
    w_d         = m_q;
    flush_d     = take_redirect;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    // Only an instruction that actually issues to ALU occupies E; a
    // stalled or flushed slot becomes a bubble.
    if (writes && !stall && !flush_q) begin
      e_d.valid = 1'b1;
      e_d.dest  = dest;
      e_d.late  = late_op;
    end

    if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_q && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others (E->M->W shifts correctly).
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      flush_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      w_q         <= w_d;
      flush_q     <= flush_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Structural invariants
  // -------------------------------------------------------------------------
`ifndef SYNTHESIS
  // A flush cycle cannot itself redirect, so flushes never run back to back.
  a_flush_single : assert property (@(posedge clk) disable iff (reset)
    flush |=> !flush);
  // A stalled or flushed slot must never steer the PC.
  a_take_clean : assert property (@(posedge clk) disable iff (reset)
    take_redirect |-> (!stall && !flush));
  a_stall_flush : assert property (@(posedge clk) disable iff (reset)
    !(stall && flush));
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed vector table (hand-derived expectations) followed by randomized
// stimulus compared against a reference model that tracks in-flight writers
// as a list of {dest, late, age} records, age 1/2/3 = ALU/DM/WB.
// Builds with or without HAZARD_FWD_EN.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int CW     = 4;   // small width so saturation is reached
  localparam int N_RAND = 3000;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam int ADD  = 1;
  localparam int SUB  = 2;
  localparam int LOAD = 4;
  localparam int BRA  = 21;
  localparam int JMP  = 22;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    rf_opc;
  logic [4:0]    rf_rs1, rf_rs2, rf_rd;
  logic          redirect_req;
  logic          stall, take_redirect, flush;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .rf_opc       (rf_opc),
    .rf_rs1       (rf_rs1),
    .rf_rs2       (rf_rs2),
    .rf_rd        (rf_rd),
    .redirect_req (redirect_req),
    .stall        (stall),
    .take_redirect(take_redirect),
    .flush        (flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // exp < 0 means "don't care" and is not counted as a comparison.
  task automatic check(input string name, input logic [31:0] act, input int exp);
    if (exp < 0) return;
    n_vec++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  typedef struct {
    int dest;
    bit late;
    int age;
  } fl_t;

  fl_t m_q[$];
  bit  m_flush;
  int  m_sc, m_fc;

  function automatic bit m_uses1(input int o); return (o >= 1 && o <= 15) || (o >= 17 && o <= 21); endfunction
  function automatic bit m_uses2(input int o); return o == 1 || o == 2 || (o >= 6 && o <= 14); endfunction
  function automatic bit m_writes(input int o); return o == 1 || o == 2 || (o >= 4 && o <= 20); endfunction
  function automatic bit m_late(input int o); return o == 4 || (o >= 6 && o <= 11); endfunction
  function automatic int m_dest(input int o, input int rs2, input int rd);
    return (o == 4 || o == 5 || (o >= 15 && o <= 20)) ? rs2 : rd;
  endfunction

  // Age of the youngest in-flight writer of r (0 = none).
  function automatic int youngest(input int r, output bit late);
    int best = 0;
    late = 1'b0;
    foreach (m_q[k])
      if (m_q[k].dest == r && (best == 0 || m_q[k].age < best)) begin
        best = m_q[k].age;
        late = m_q[k].late;
      end
    return best;
  endfunction

  task automatic model_eval(output int es, output int et, output int efa, output int efb);
    int  o, a1, a2;
    bit  l1, l2, h1, h2, u1, u2;
    o  = int'(rf_opc);
    u1 = m_uses1(o);
    u2 = m_uses2(o);
    a1 = youngest(int'(rf_rs1), l1);
    a2 = youngest(int'(rf_rs2), l2);
    if (FWD) begin
      h1 = (a1 != 0) && l1 && (a1 <= 2);
      h2 = (a2 != 0) && l2 && (a2 <= 2);
    end else begin
      h1 = (a1 != 0);
      h2 = (a2 != 0);
    end
    es  = (!reset && !m_flush && ((u1 && h1) || (u2 && h2))) ? 1 : 0;
    et  = (!reset && redirect_req && es == 0 && !m_flush) ? 1 : 0;
    efa = (FWD && !reset && u1) ? a1 : 0;
    efb = (FWD && !reset && u2) ? a2 : 0;
  endtask

  task automatic model_step(input int es, input int et);
    fl_t nq[$];
    int  o;
    if (reset) begin
      m_q.delete();
      m_flush = 1'b0;
      m_sc    = 0;
      m_fc    = 0;
      return;
    end
    o = int'(rf_opc);
    if (es != 0 && m_sc < (1 << CW) - 1) m_sc++;
    if (m_flush && m_fc < (1 << CW) - 1) m_fc++;
    foreach (m_q[k])
      if (m_q[k].age < 3) begin
        fl_t t;
        t = m_q[k];
        t.age++;
        nq.push_back(t);
      end
    if (m_writes(o) && es == 0 && !m_flush) begin
      fl_t t;
      t.dest = m_dest(o, int'(rf_rs2), int'(rf_rd));
      t.late = m_late(o);
      t.age  = 1;
      nq.push_back(t);
    end
    m_q     = nq;
    m_flush = (et != 0);
  endtask

  // ---------------------------------------------------------------------
  // Vectors
  // ---------------------------------------------------------------------
  typedef struct {
    bit rst;
    int opc, rs1, rs2, rd;
    bit req;
    int s, t, f, fa, fb, sc, fc;   // expected outputs, -1 = don't care
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input bit rst, input int opc, input int rs1, input int rs2,
                             input int rd, input bit req, input int s, input int t,
                             input int f, input int fa, input int fb, input int sc,
                             input int fc);
    vec_t r;
    r.rst = rst; r.opc = opc; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.req = req;
    r.s = s; r.t = t; r.f = f; r.fa = fa; r.fb = fb; r.sc = sc; r.fc = fc;
    return r;
  endfunction

  task automatic step(input vec_t x, input bit use_model, input int idx);
    int es, et, efa, efb;
    string p;
    reset        = x.rst;
    rf_opc       = 6'(x.opc);
    rf_rs1       = 5'(x.rs1);
    rf_rs2       = 5'(x.rs2);
    rf_rd        = 5'(x.rd);
    redirect_req = x.req;
    @(negedge clk);
    model_eval(es, et, efa, efb);
    if (use_model) begin
      p = $sformatf("rand%0d", idx);
      check({p, " stall"}, 32'(stall), es);
      check({p, " take_redirect"}, 32'(take_redirect), et);
      check({p, " flush"}, 32'(flush), int'(m_flush));
      check({p, " fwd_a"}, 32'(fwd_a), efa);
      check({p, " fwd_b"}, 32'(fwd_b), efb);
      check({p, " stall_cnt"}, 32'(stall_cnt), m_sc);
      check({p, " flush_cnt"}, 32'(flush_cnt), m_fc);
    end else begin
      p = $sformatf("row%0d", idx);
      check({p, " stall"}, 32'(stall), x.s);
      check({p, " take_redirect"}, 32'(take_redirect), x.t);
      check({p, " flush"}, 32'(flush), x.f);
      check({p, " fwd_a"}, 32'(fwd_a), x.fa);
      check({p, " fwd_b"}, 32'(fwd_b), x.fb);
      check({p, " stall_cnt"}, 32'(stall_cnt), x.sc);
      check({p, " flush_cnt"}, 32'(flush_cnt), x.fc);
    end
    @(posedge clk);
    model_step(es, et);
    #1;
  endtask

  initial begin
    reset = 1'b1; rf_opc = '0; rf_rs1 = '0; rf_rs2 = '0; rf_rd = '0; redirect_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_q.delete(); m_flush = 1'b0; m_sc = 0; m_fc = 0;

    //               rst opc  rs1 rs2 rd req  stl tak fl  fa  fb  sc  fc
`ifndef HAZARD_FWD_EN
    // Reset state; redirect request ignored while in reset.
    tbl.push_back(v(1, BRA,  2,  0, 0, 1,   0,  0,  0,  0,  0,  0,  0));
    // ADD r3<-r1,r2 then ADD r4<-r3,r5: three stalls, issues on the 4th.
    tbl.push_back(v(0, ADD,  1,  2, 3, 0,   0,  0,  0,  0,  0,  0,  0));
    tbl.push_back(v(0, ADD,  3,  5, 4, 0,   1,  0,  0,  0,  0,  0,  0));
    tbl.push_back(v(0, ADD,  3,  5, 4, 0,   1,  0,  0,  0,  0,  1,  0));
    tbl.push_back(v(0, ADD,  3,  5, 4, 0,   1,  0,  0,  0,  0,  2,  0));
    tbl.push_back(v(0, ADD,  3,  5, 4, 0,   0,  0,  0,  0,  0,  3,  0));
    // The released ADD r4 is in E now; a consumer two slots later sees it in M.
    tbl.push_back(v(0,   0,  4,  4, 0, 0,   0,  0,  0,  0,  0,  3,  0));
    tbl.push_back(v(0, ADD,  0,  4, 6, 0,   1,  0,  0,  0,  0,  3,  0));
    tbl.push_back(v(0, ADD,  0,  4, 6, 0,   1,  0,  0,  0,  0,  4,  0));
    tbl.push_back(v(0, ADD,  0,  4, 6, 0,   0,  0,  0,  0,  0,  5,  0));
    // Branch on a pending r2: no redirect while stalled, redirect on release.
    tbl.push_back(v(0, ADD,  1,  1, 2, 0,   0,  0,  0,  0,  0,  5,  0));
    tbl.push_back(v(0, BRA,  2,  0, 0, 1,   1,  0,  0,  0,  0,  5,  0));
    tbl.push_back(v(0, BRA,  2,  0, 0, 1,   1,  0,  0,  0,  0,  6,  0));
    tbl.push_back(v(0, BRA,  2,  0, 0, 1,   1,  0,  0,  0,  0,  7,  0));
    tbl.push_back(v(0, BRA,  2,  0, 0, 1,   0,  1,  0,  0,  0,  8,  0));
    // Wrong-path ADD r9 (its own request ignored), then a consumer of r9.
    tbl.push_back(v(0, ADD,  2,  2, 9, 1,   0,  0,  1,  0,  0,  8,  0));
    tbl.push_back(v(0, ADD,  9,  9,10, 0,   0,  0,  0,  0,  0,  8,  1));
    // JUMP; wrong-path ADD r9 reads a pending r5 but must not stall.
    tbl.push_back(v(0, ADD,  1,  1, 5, 0,   0,  0,  0,  0,  0,  8,  1));
    tbl.push_back(v(0, JMP,  0,  0, 0, 1,   0,  1,  0,  0,  0,  8,  1));
    tbl.push_back(v(0, ADD,  5,  5, 9, 1,   0,  0,  1,  0,  0,  8,  1));
    tbl.push_back(v(0, ADD,  9,  0,11, 0,   0,  0,  0,  0,  0,  8,  2));
    // Reset in the middle of a stall empties the shadow pipeline.
    tbl.push_back(v(0, ADD,  1,  1, 7, 0,   0,  0,  0,  0,  0,  8,  2));
    tbl.push_back(v(0, ADD,  7,  1, 8, 0,   1,  0,  0,  0,  0,  8,  2));
    tbl.push_back(v(0, ADD,  7,  1, 8, 0,   1,  0,  0,  0,  0,  9,  2));
    tbl.push_back(v(1, ADD,  7,  1, 8, 1,   0,  0,  0,  0,  0, 10,  2));
    tbl.push_back(v(0, ADD,  7,  1, 8, 0,   0,  0,  0,  0,  0,  0,  0));
    // LOAD r7 then SUB using r7: three stalls without forwarding.
    tbl.push_back(v(0, LOAD, 1,  7, 0, 0,   0,  0,  0,  0,  0,  0,  0));
    tbl.push_back(v(0, SUB,  7,  7, 8, 0,   1,  0,  0,  0,  0,  0,  0));
    tbl.push_back(v(0, SUB,  7,  7, 8, 0,   1,  0,  0,  0,  0,  1,  0));
    tbl.push_back(v(0, SUB,  7,  7, 8, 0,   1,  0,  0,  0,  0,  2,  0));
    tbl.push_back(v(0, SUB,  7,  7, 8, 0,   0,  0,  0,  0,  0,  3,  0));
`else
    tbl.push_back(v(1, BRA,  2,  0, 0, 1,   0,  0,  0,  0,  0,  0,  0));
    // ALU->ALU: no stall, operand A from the ALU stage.
    tbl.push_back(v(0, ADD,  1,  2, 3, 0,   0,  0,  0,  0,  0,  0,  0));
    tbl.push_back(v(0, ADD,  3,  5, 4, 0,   0,  0,  0,  1,  0,  0,  0));
    // Load-use: two stalls, then both operands from WB.
    tbl.push_back(v(0, LOAD, 1,  7, 0, 0,   0,  0,  0,  0,  0,  0,  0));
    tbl.push_back(v(0, SUB,  7,  7, 8, 0,   1,  0,  0, -1, -1,  0,  0));
    tbl.push_back(v(0, SUB,  7,  7, 8, 0,   1,  0,  0, -1, -1,  1,  0));
    tbl.push_back(v(0, SUB,  7,  7, 8, 0,   0,  0,  0,  3,  3,  2,  0));
    tbl.push_back(v(0, ADD,  4,  8, 9, 0,   0,  0,  0,  0,  1,  2,  0));
    // Redirect still squashes one slot.
    tbl.push_back(v(0, JMP,  0,  0, 0, 1,   0,  1,  0,  0,  0,  2,  0));
    tbl.push_back(v(0, ADD,  9,  9, 9, 1,   0,  0,  1,  0,  0,  2,  0));
    tbl.push_back(v(0, ADD,  9,  0, 1, 0,   0,  0,  0,  0,  0,  2,  1));
`endif

    foreach (tbl[i]) step(tbl[i], 1'b0, i);

    // Randomized phase: narrow register set and opcode range to make
    // hazards, redirects and saturation frequent.
    step(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, -1);
    for (int n = 0; n < N_RAND; n++) begin
      vec_t x;
      x.rst = ($urandom_range(0, 99) == 0);
      x.opc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63))
                                          : int'($urandom_range(0, 23));
      x.rs1 = int'($urandom_range(0, 3));
      x.rs2 = int'($urandom_range(0, 3));
      x.rd  = int'($urandom_range(0, 3));
      x.req = ($urandom_range(0, 2) == 0);
      x.s = -1; x.t = -1; x.f = -1; x.fa = -1; x.fb = -1; x.sc = -1; x.fc = -1;
      step(x, 1'b1, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
